// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encodings, widths, default magic.
package imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [BYTE_W-1:0] DEF_MAGIC = 8'hA5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_CNT_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8->32 assembler: collects three bytes, the fourth completes the word combinationally.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    logic [1:0]            byte_idx;
    logic [3*BYTE_W-1:0]   lo_bytes;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= 2'd0;
            lo_bytes <= '0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            lo_bytes <= '0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    lo_bytes[7:0]   <= byte_in;
                2'd1:    lo_bytes[15:8]  <= byte_in;
                2'd2:    lo_bytes[23:16] <= byte_in;
                default: lo_bytes        <= lo_bytes;
            endcase
        end
    end

    // Fourth byte goes straight to the output so the word register can capture it on the same edge.
    assign word_valid_c = byte_en && !clear && (byte_idx == 2'd3);
    assign word_c       = {byte_in, lo_bytes};

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem writer: framed byte stream -> word writes, holds CPU in reset until image is loaded.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned        DEPTH_WORDS = 128,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = 32'h0,
    parameter logic [BYTE_W-1:0]  MAGIC       = DEF_MAGIC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              done,
    output logic              error,
    output logic              cpu_reset_n
);

    logic [2:0]        state, state_nxt;
    logic [BYTE_W-1:0] n_lo, n_lo_nxt;
    logic [CNT_W-1:0]  n_words, n_words_nxt;
    logic [CNT_W-1:0]  word_cnt, word_cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [WORD_W-1:0] wdata_nxt;
    logic              we_nxt, done_nxt, error_nxt, ready_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum, csum_nxt;
`endif

    logic              accept;
    logic              pk_clear, pk_en;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;
    logic [CNT_W-1:0]  n_c;

    assign accept   = in_valid && in_ready;
    assign pk_clear = accept && (state == S_IDLE) && (in_data == MAGIC);
    assign pk_en    = accept && (state == S_DATA);
    assign n_c      = {in_data, n_lo};

    byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (pk_clear),
        .byte_en      (pk_en),
        .byte_in      (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            n_lo        <= '0;
            n_words     <= '0;
            word_cnt    <= '0;
            in_ready    <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= BASE_ADDR;
            mem_wdata   <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            state       <= state_nxt;
            n_lo        <= n_lo_nxt;
            n_words     <= n_words_nxt;
            word_cnt    <= word_cnt_nxt;
            in_ready    <= ready_nxt;
            mem_we      <= we_nxt;
            mem_addr    <= addr_nxt;
            mem_wdata   <= wdata_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
            cpu_reset_n <= done_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum        <= csum_nxt;
`endif
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt    = state;
        n_lo_nxt     = n_lo;
        n_words_nxt  = n_words;
        word_cnt_nxt = word_cnt;
        we_nxt       = 1'b0;
        wdata_nxt    = mem_wdata;
        addr_nxt     = mem_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_nxt     = csum;
`endif

        if (mem_we) begin
            addr_nxt = mem_addr + ADDR_W'(4);
        end

        case (state)
            S_IDLE: begin
                if (pk_clear) begin
                    state_nxt    = S_CNT_LO;
                    word_cnt_nxt = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_nxt     = '0;
`endif
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    n_lo_nxt  = in_data;
                    state_nxt = S_CNT_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_nxt  = csum ^ in_data;
`endif
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    n_words_nxt = n_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_nxt    = csum ^ in_data;
`endif
                    if (n_c > CNT_W'(DEPTH_WORDS)) begin
                        state_nxt = S_ERROR;
                    end else if (n_c == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    csum_nxt = csum ^ in_data;
                end
`endif
                if (word_valid_c) begin
                    we_nxt       = 1'b1;
                    wdata_nxt    = word_c;
                    word_cnt_nxt = word_cnt + CNT_W'(1);
                    if (word_cnt == n_words - CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_IDLE;
                    addr_nxt  = BASE_ADDR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // done trails entry into DONE by a cycle so it rises after the final write strobe
        done_nxt  = (state == S_DONE) && (state_nxt == S_DONE);
        error_nxt = (state_nxt == S_ERROR);
        ready_nxt = (state_nxt != S_DONE) && (state_nxt != S_ERROR);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus, checked by a write monitor.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        error;
    logic        cpu_reset_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    imem_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (done),
        .error       (error),
        .cpu_reset_n (cpu_reset_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h want no write", mem_addr, mem_wdata);
            end else begin
                check("write_addr", mem_addr, exp_addr_q.pop_front());
                check("write_data", mem_wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0 want 1");
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_frame(input byte_q_t f, input bit with_csum);
        logic [7:0] x;
        x = 8'h00;
        foreach (f[i]) begin
            send_byte(f[i]);
            if (i > 0) x = x ^ f[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (with_csum) send_byte(x);
`else
        if (with_csum && x === 8'hxx) send_byte(x);
`endif
        idle();
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got done 0 error 0 want done or error", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_done_clr"}, 32'(done), 32'd0);
        check({name, "_err_clr"}, 32'(error), 32'd0);
        check({name, "_cpu_rst"}, 32'(cpu_reset_n), 32'd0);
        check({name, "_addr_base"}, mem_addr, 32'h0);
        check({name, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_done(input string name, input logic [31:0] end_addr);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_cpu_rst"}, 32'(cpu_reset_n), 32'd1);
        check({name, "_ready"}, 32'(in_ready), 32'd0);
        check({name, "_addr"}, mem_addr, end_addr);
        check({name, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string name);
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        check({name, "_we"}, 32'(mem_we), 32'd0);
        check({name, "_addr"}, mem_addr, 32'h0);
        check({name, "_wdata"}, mem_wdata, 32'h0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_cpu_rst"}, 32'(cpu_reset_n), 32'd0);
    endtask

    initial begin
        byte_q_t frame;
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;

        // Two-word image
        expect_write(32'h0, 32'h00100093);
        expect_write(32'h4, 32'h00100113);
        frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        send_frame(frame, 1'b1);
        wait_end("t1");
        check_done("t1", 32'h8);
        pulse_start("t1_start");

        // Garbage before the magic byte is dropped
        expect_write(32'h0, 32'h0020a1b3);
        send_byte(8'h00);
        send_byte(8'hFF);
        frame = '{8'hA5, 8'h01, 8'h00, 8'hB3, 8'hA1, 8'h20, 8'h00};
        send_frame(frame, 1'b1);
        wait_end("t2");
        check_done("t2", 32'h4);
        pulse_start("t2_start");

        // Oversized count is rejected
        frame = '{8'hA5, 8'h81, 8'h00};
        send_frame(frame, 1'b0);
        wait_end("t3");
        check("t3_error", 32'(error), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_cpu_rst", 32'(cpu_reset_n), 32'd0);
        check("t3_pending", 32'(exp_addr_q.size()), 32'd0);
        pulse_start("t3_start");

        // Reset in the middle of the second word
        expect_write(32'h0, 32'h00100093);
        frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01};
        send_frame(frame, 1'b0);
        repeat (2) @(negedge clk);
        check("t4_partial_addr", mem_addr, 32'h4);
        reset_n = 1'b0;
        #1;
        check_reset("t4_reset");
        @(negedge clk);
        reset_n = 1'b1;
        expect_write(32'h0, 32'h00100093);
        expect_write(32'h4, 32'h00100113);
        frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        send_frame(frame, 1'b1);
        wait_end("t4");
        check_done("t4", 32'h8);
        pulse_start("t4_start");

        // Empty image
        frame = '{8'hA5, 8'h00, 8'h00};
        send_frame(frame, 1'b1);
        wait_end("t5");
        check_done("t5", 32'h0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start("t5_start");
        expect_write(32'h0, 32'h00100093);
        frame = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h82};
        send_frame(frame, 1'b0);
        wait_end("t6a");
        check_done("t6a", 32'h4);
        pulse_start("t6a_start");

        expect_write(32'h0, 32'h00100093);
        frame = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        send_frame(frame, 1'b0);
        wait_end("t6b");
        check("t6b_error", 32'(error), 32'd1);
        check("t6b_done", 32'(done), 32'd0);
        check("t6b_cpu_rst", 32'(cpu_reset_n), 32'd0);
        check("t6b_pending", 32'(exp_addr_q.size()), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
